sram_bank_sequencer: RTL and testbench

- Per-bennett-cycle access controller for the 32x16 two-port SRAM bank (sram_2port_bank).
- Arbitrates one read requester and one write requester, then drives Addr_A/Addr_B, in, ReadEn, WriteEn and RegWrtBar on the phase schedule the bank needs.
- Captures read data and returns it with a valid pulse.
- Runs on the master clk that feeds the bennett clock; one bank operation per PHASES-clk cycle.

---
 rtl/sram_bank_sequencer.sv | 136 +++++++++++++
 tb/tb_sram_bank_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_sequencer.sv
// Phase-scheduled access controller for the 32x16 two-port SRAM bank.
// Arbitrates one reader and one writer per bennett cycle.
module sram_bank_sequencer #(
  parameter int PHASES  = 10,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16,
  parameter int ADDR_PH = 2,
  parameter int DATA_PH = 4,
  parameter int EN_PH   = 6,
  parameter int WE_PH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_read_en,
  output logic              sram_write_en,
  output logic              sram_regwrt_bar,
  input  logic [DATA_W-1:0] sram_dout_a,
  input  logic [DATA_W-1:0] sram_dout_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              busy,
  output logic [3:0]        phase
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  localparam logic [3:0] P_LAST = 4'(PHASES - 1);
  localparam logic [3:0] P_ADDR = 4'(ADDR_PH);
  localparam logic [3:0] P_DATA = 4'(DATA_PH);
  localparam logic [3:0] P_EN   = 4'(EN_PH);
  localparam logic [3:0] P_EN1  = 4'(EN_PH + 1);
  localparam logic [3:0] P_WE   = 4'(WE_PH);

  state_t            state;
  state_t            st_nx;
  logic              prio;
  logic [3:0]        nph;
  logic [ADDR_W-1:0] op_a;
  logic [ADDR_W-1:0] op_b;
  logic [DATA_W-1:0] op_d;
  logic              at0;
  logic              g_rd;
  logic              g_wr;
  logic              rdn;
  logic              wrn;
  logic              cap;

  // prio=0 favours the reader when both request at once
  always_comb begin
    at0   = (state == IDLE) && (phase == 4'd0) && !sync;
    g_rd  = at0 && rd_req && (!wr_req || !prio);
    g_wr  = at0 && wr_req && (!rd_req || prio);
    nph   = (sync || phase == P_LAST) ? 4'd0 : phase + 4'd1;
    st_nx = state;
    if (sync)
      st_nx = IDLE;
    else if (g_rd)
      st_nx = READ;
    else if (g_wr)
      st_nx = WRITE;
    else if (state != IDLE && phase == P_LAST)
      st_nx = IDLE;
    rdn = (st_nx == READ);
    wrn = (st_nx == WRITE);
    cap = (state == READ) && (phase == P_WE) && !sync;
  end

  // acks are masked by reset so every output is 0 while it is held
  assign rd_ack = g_rd & reset;
  assign wr_ack = g_wr & reset;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      phase           <= '0;
      prio            <= 1'b0;
      op_a            <= '0;
      op_b            <= '0;
      op_d            <= '0;
      sram_addr_a     <= '0;
      sram_addr_b     <= '0;
      sram_din        <= '0;
      sram_read_en    <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_regwrt_bar <= 1'b0;
      rd_data_a       <= '0;
      rd_data_b       <= '0;
      rd_valid        <= 1'b0;
    end else begin
      phase <= nph;
      state <= st_nx;
      if (g_rd) begin
        op_a <= rd_addr_a;
        op_b <= rd_addr_b;
        op_d <= '0;
      end else if (g_wr) begin
        op_a <= wr_addr;
        op_b <= wr_addr;
        op_d <= wr_data;
      end
      if (at0 && rd_req && wr_req)
        prio <= ~prio;
      // outputs are loaded for the phase being entered
      sram_addr_a     <= ((rdn || wrn) && nph >= P_ADDR) ? op_a : '0;
      sram_addr_b     <= ((rdn || wrn) && nph >= P_ADDR) ? op_b : '0;
      sram_din        <= (wrn && nph >= P_DATA) ? op_d : '0;
      sram_read_en    <= rdn && (nph == P_EN || nph == P_EN1);
      sram_regwrt_bar <= wrn && (nph >= P_EN);
      sram_write_en   <= wrn && (nph == P_WE);
      rd_valid        <= cap;
      if (cap) begin
        rd_data_a <= sram_dout_a;
        rd_data_b <= sram_dout_b;
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Directed checks for sram_bank_sequencer: vector table for the
// single write/read schedules, hand sequences for arbitration and aborts.
module tb_sram_bank_sequencer;

  logic        clk;
  logic        reset;
  logic        sync;
  logic        rd_req;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        rd_ack;
  logic        wr_req;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [4:0]  sram_addr_a;
  logic [4:0]  sram_addr_b;
  logic [15:0] sram_din;
  logic        sram_read_en;
  logic        sram_write_en;
  logic        sram_regwrt_bar;
  logic [15:0] sram_dout_a;
  logic [15:0] sram_dout_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        rd_valid;
  logic        busy;
  logic [3:0]  phase;

  int total = 0;
  int bad   = 0;

  sram_bank_sequencer dut (
    .clk(clk), .reset(reset), .sync(sync),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack),
    .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b),
    .sram_din(sram_din), .sram_read_en(sram_read_en),
    .sram_write_en(sram_write_en), .sram_regwrt_bar(sram_regwrt_bar),
    .sram_dout_a(sram_dout_a), .sram_dout_b(sram_dout_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_valid(rd_valid), .busy(busy), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        wq;
    logic [3:0]  ph;
    logic        ra;
    logic        wa;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [15:0] din;
    logic        re;
    logic        we;
    logic        rw;
    logic        rv;
    logic        bz;
    logic [15:0] da;
    logic [15:0] db;
  } vec_t;

  function automatic vec_t mk(int rr, int wq, int ph, int ra, int wa,
                              int aa, int ab, int din, int re, int we,
                              int rw, int rv, int bz, int da, int db);
    vec_t v;
    v.rr = 1'(rr);   v.wq = 1'(wq);   v.ph = 4'(ph);
    v.ra = 1'(ra);   v.wa = 1'(wa);
    v.aa = 5'(aa);   v.ab = 5'(ab);   v.din = 16'(din);
    v.re = 1'(re);   v.we = 1'(we);   v.rw = 1'(rw);
    v.rv = 1'(rv);   v.bz = 1'(bz);
    v.da = 16'(da);  v.db = 16'(db);
    return v;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input vec_t e);
    chk(tag, "phase", 32'(phase), 32'(e.ph));
    chk(tag, "rd_ack", 32'(rd_ack), 32'(e.ra));
    chk(tag, "wr_ack", 32'(wr_ack), 32'(e.wa));
    chk(tag, "addr_a", 32'(sram_addr_a), 32'(e.aa));
    chk(tag, "addr_b", 32'(sram_addr_b), 32'(e.ab));
    chk(tag, "din", 32'(sram_din), 32'(e.din));
    chk(tag, "read_en", 32'(sram_read_en), 32'(e.re));
    chk(tag, "write_en", 32'(sram_write_en), 32'(e.we));
    chk(tag, "regwrt", 32'(sram_regwrt_bar), 32'(e.rw));
    chk(tag, "rd_valid", 32'(rd_valid), 32'(e.rv));
    chk(tag, "busy", 32'(busy), 32'(e.bz));
    chk(tag, "rd_data_a", 32'(rd_data_a), 32'(e.da));
    chk(tag, "rd_data_b", 32'(rd_data_b), 32'(e.db));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      total++;
      if ((sram_read_en && sram_write_en) ||
          (sram_write_en && !sram_regwrt_bar)) begin
        bad++;
        $display("FAIL invariant: re=%b we=%b rw=%b", sram_read_en,
                 sram_write_en, sram_regwrt_bar);
      end
    end
  end

  vec_t tbl[20];
  int   n_we;
  int   n_rv;

  initial begin
    tbl[0]  = mk(0,1,0, 0,1, 0,0,0, 0,0,0,0,0, 0,0);
    tbl[1]  = mk(0,0,1, 0,0, 0,0,0, 0,0,0,0,1, 0,0);
    tbl[2]  = mk(0,0,2, 0,0, 'h1F,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[3]  = mk(0,0,3, 0,0, 'h1F,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[4]  = mk(0,0,4, 0,0, 'h1F,'h1F,'hAAAA, 0,0,0,0,1, 0,0);
    tbl[5]  = mk(0,0,5, 0,0, 'h1F,'h1F,'hAAAA, 0,0,0,0,1, 0,0);
    tbl[6]  = mk(0,0,6, 0,0, 'h1F,'h1F,'hAAAA, 0,0,1,0,1, 0,0);
    tbl[7]  = mk(0,0,7, 0,0, 'h1F,'h1F,'hAAAA, 0,0,1,0,1, 0,0);
    tbl[8]  = mk(0,0,8, 0,0, 'h1F,'h1F,'hAAAA, 0,1,1,0,1, 0,0);
    tbl[9]  = mk(0,0,9, 0,0, 'h1F,'h1F,'hAAAA, 0,0,1,0,1, 0,0);
    tbl[10] = mk(1,0,0, 1,0, 0,0,0, 0,0,0,0,0, 0,0);
    tbl[11] = mk(0,0,1, 0,0, 0,0,0, 0,0,0,0,1, 0,0);
    tbl[12] = mk(0,0,2, 0,0, 0,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[13] = mk(0,0,3, 0,0, 0,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[14] = mk(0,0,4, 0,0, 0,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[15] = mk(0,0,5, 0,0, 0,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[16] = mk(0,0,6, 0,0, 0,'h1F,0, 1,0,0,0,1, 0,0);
    tbl[17] = mk(0,0,7, 0,0, 0,'h1F,0, 1,0,0,0,1, 0,0);
    tbl[18] = mk(0,0,8, 0,0, 0,'h1F,0, 0,0,0,0,1, 0,0);
    tbl[19] = mk(0,0,9, 0,0, 0,'h1F,0, 0,0,0,1,1, 'h0100,'hAAAA);

    reset = 1'b0; sync = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_addr_a = 5'h00; rd_addr_b = 5'h1F;
    wr_addr = 5'h1F; wr_data = 16'hAAAA;
    sram_dout_a = 16'h0100; sram_dout_b = 16'hAAAA;

    step(); step(); #1;
    cmp("in_reset", mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0));

    step(); reset = 1'b1; #1;
    cmp("idle0", mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0));
    for (int i = 1; i < 20; i++) begin
      step(); #1;
      cmp("idle", mk(0,0,i%10, 0,0, 0,0,0, 0,0,0,0,0, 0,0));
    end

    for (int r = 0; r < 20; r++) begin
      step();
      rd_req = tbl[r].rr;
      wr_req = tbl[r].wq;
      #1;
      cmp($sformatf("vec%0d", r), tbl[r]);
    end

    n_we = 0; n_rv = 0;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 10; p++) begin
        step();
        rd_req = 1'b1; wr_req = 1'b1;
        #1;
        n_we += int'(sram_write_en);
        n_rv += int'(rd_valid);
        chk($sformatf("rr%0d_%0d", c, p), "phase", 32'(phase), 32'(p));
        chk($sformatf("rr%0d_%0d", c, p), "rd_ack", 32'(rd_ack),
            32'(p == 0 && c % 2 == 0));
        chk($sformatf("rr%0d_%0d", c, p), "wr_ack", 32'(wr_ack),
            32'(p == 0 && c % 2 == 1));
        chk($sformatf("rr%0d_%0d", c, p), "busy", 32'(busy), 32'(p != 0));
      end
    end
    step(); rd_req = 1'b0; wr_req = 1'b0; #1;
    chk("rr_end", "rd_ack", 32'(rd_ack), 32'd0);
    chk("rr_end", "busy", 32'(busy), 32'd0);
    chk("rr", "we_pulses", 32'(n_we), 32'd2);
    chk("rr", "rv_pulses", 32'(n_rv), 32'd2);

    wr_addr = 5'h0A; wr_data = 16'h5555;
    n_we = 0;
    wr_req = 1'b1; #1;
    chk("abort", "wr_ack", 32'(wr_ack), 32'd1);
    for (int p = 1; p <= 7; p++) begin
      step();
      wr_req = 1'b0;
      if (p == 7) sync = 1'b1;
      #1;
      n_we += int'(sram_write_en);
    end
    chk("abort7", "regwrt", 32'(sram_regwrt_bar), 32'd1);
    chk("abort7", "addr_a", 32'(sram_addr_a), 32'h0A);
    chk("abort7", "din", 32'(sram_din), 32'h5555);
    step(); sync = 1'b0; #1;
    cmp("abort_nx", mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 'h0100,'hAAAA));
    for (int p = 1; p <= 10; p++) begin
      step(); #1;
      n_we += int'(sram_write_en);
      chk($sformatf("abort_idle%0d", p), "busy", 32'(busy), 32'd0);
    end
    chk("abort", "we_pulses", 32'(n_we), 32'd0);

    rd_addr_a = 5'h03; rd_addr_b = 5'h04;
    rd_req = 1'b1; #1;
    chk("rst_rd", "rd_ack", 32'(rd_ack), 32'd1);
    for (int p = 1; p <= 5; p++) begin
      step(); rd_req = 1'b0; #1;
    end
    chk("rst_rd5", "addr_a", 32'(sram_addr_a), 32'h03);
    chk("rst_rd5", "addr_b", 32'(sram_addr_b), 32'h04);
    reset = 1'b0; rd_req = 1'b1; #1;
    cmp("rst_async", mk(0,0,0, 0,0, 0,0,0, 0,0,0,0,0, 0,0));
    step();
    reset = 1'b1;
    sram_dout_a = 16'h1234; sram_dout_b = 16'h5678;
    #1;
    chk("rst_rel", "phase", 32'(phase), 32'd0);
    chk("rst_rel", "rd_ack", 32'(rd_ack), 32'd1);
    n_rv = 0;
    for (int p = 1; p <= 9; p++) begin
      step(); rd_req = 1'b0; #1;
      n_rv += int'(rd_valid);
      if (p == 9) begin
        chk("rst_rd9", "rd_valid", 32'(rd_valid), 32'd1);
        chk("rst_rd9", "rd_data_a", 32'(rd_data_a), 32'h1234);
        chk("rst_rd9", "rd_data_b", 32'(rd_data_b), 32'h5678);
      end
    end
    chk("rst", "rv_pulses", 32'(n_rv), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
